cm_lat_buf: RTL

- Credit-based catch buffer placed directly downstream of a fixed-latency pipeline, such as a cm_shr delay line or a pipelined RAM read.
- Upstream logic issues a request only while o_credit is high. The result returns some fixed number of cycles later on i_vld/i_data.
- The block guarantees that every returning result has a free slot, then presents stored results to a valid/ready consumer in order.
- The returning data path has no backpressure. Correct credit accounting is the only overflow protection.

---
 rtl/cm_lat_buf.sv | 83 ++++++++
 1 files changed

// File: rtl/cm_lat_buf.sv
// Credit-based catch buffer for the output of a fixed-latency pipeline.
// Credits cover in-flight requests plus stored results, so every return has a free slot.
module cm_lat_buf #(
    parameter int  DEPTH = 4,
    parameter type DTYPE = logic [7:0]
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_credit,
    input  logic                         i_issue,
    input  logic                         i_vld,
    input  DTYPE                         i_data,
    output logic                         o_vld,
    output DTYPE                         o_data,
    input  logic                         i_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    DTYPE          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] infl;
    logic          err;

    logic          iss;
    logic          pop;
    logic          ret;
    logic          push;
    logic          err_set;
    logic [CW:0]   occ;

    // Consumer side: a beat transfers on a cycle where o_vld and i_rdy are both high;
    // o_vld/o_data stay stable while i_rdy is low. The return side has no backpressure.
    assign occ      = {1'b0, infl} + {1'b0, count};
    assign o_credit = (occ < {1'b0, FULL});
    assign o_vld    = (count != '0);
    assign o_data   = mem[rd_ptr];
    assign o_count  = count;
    assign o_err    = err;

    assign iss  = i_issue & o_credit;
    assign pop  = o_vld & i_rdy;
    // A return with infl != 0 completes a request even if it is dropped for overflow.
    assign ret  = i_vld & (infl != '0);
    assign push = ret & ((count < FULL) | pop);

    assign err_set = (i_issue & ~o_credit)
                   | (i_vld & (infl == '0))
                   | (i_vld & (count == FULL) & ~pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            infl   <= '0;
            err    <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            infl  <= infl + CW'(iss) - CW'(ret);
            if (err_set)
                err <= 1'b1;
        end
    end

    // Storage is not reset; only the pointers and counters define what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push)
            mem[wr_ptr] <= i_data;
    end

endmodule
